// File: rtl/mult_arb_pkg.sv
// Shared constants, tag type and width helpers for mult_arbiter.
// Optional feature macro used by the top: MULT_ARB_STATS_EN.
package mult_arb_pkg;

   localparam int DW_DEF   = 8;
   localparam int MLAT_DEF = 3;
   localparam int NREQ_MAX = 8;
   localparam int IDW_MAX  = 3;

   function automatic int rw_of(input int dw);
      return 2 * dw + 1;
   endfunction

   function automatic int idw_of(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   typedef struct packed {
      logic               valid;
      logic [IDW_MAX-1:0] id;
   } tag_t;

endpackage

// File: rtl/pipeline_mult.sv
// Fixed-latency a*b+c multiplier, no stall.
// Ports: clk, rst_n, a/b/c operands, result.
// The operands are expected straight from flops: that operand register
// is the first of the MLAT stages, so MLAT-1 stages live in here.
module pipeline_mult #(
   parameter  int DW   = 8,
   parameter  int MLAT = 3,
   localparam int RW   = 2 * DW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   input  logic [DW-1:0] c,
   output logic [RW-1:0] result
);

   logic [RW-1:0] prod;

   assign prod = RW'(a) * RW'(b) + RW'(c);

   if (MLAT < 2) begin : g_comb
      assign result = prod;
   end else begin : g_pipe
      logic [RW-1:0] pipe_q [MLAT-1];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int i = 0; i < MLAT - 1; i++) pipe_q[i] <= '0;
         end else begin
            pipe_q[0] <= prod;
            for (int i = 1; i < MLAT - 1; i++) pipe_q[i] <= pipe_q[i-1];
         end
      end

      assign result = pipe_q[MLAT-2];
   end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts at ptr and wraps.
// Ports: clk, rst, req_valid_i, adv_i (handshake), grant_o (one-hot), id_o.
module rr_arbiter
   import mult_arb_pkg::*;
#(
   parameter  int NREQ = 4,
   localparam int IDW  = idw_of(NREQ)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req_valid_i,
   input  logic            adv_i,
   output logic [NREQ-1:0] grant_o,
   output logic [IDW-1:0]  id_o
);

   logic [IDW-1:0]    ptr_q, ptr_d;
   logic [2*NREQ-1:0] dbl;
   logic [IDW:0]      sum;
   logic              found;

   // Doubling the request vector turns the wrapped search into a plain
   // first-set scan starting at bit 0 of the shifted copy.
   always_comb begin
      dbl   = {req_valid_i, req_valid_i} >> ptr_q;
      found = 1'b0;
      sum   = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!found && dbl[k]) begin
            found = 1'b1;
            sum   = {1'b0, ptr_q} + (IDW+1)'(k);
         end
      end
      if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
      id_o    = sum[IDW-1:0];
      grant_o = found ? (NREQ'(1) << id_o) : '0;
   end

   always_comb begin
      ptr_d = ptr_q;
      if (adv_i) begin
         ptr_d = (id_o == IDW'(NREQ - 1)) ? '0 : id_o + IDW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one pipelined multiplier between NREQ requesters, tagging each
// issue with its requester id and steering the result back.
// Ports: clk, rst, req_valid/ready/a/b/c, mult_a/b/c, mult_result,
// rsp_valid/rsp_data, busy; grant_cnt when MULT_ARB_STATS_EN is defined.
module mult_arbiter
   import mult_arb_pkg::*;
#(
   parameter  int NREQ = 4,
   parameter  int DW   = DW_DEF,
   parameter  int MLAT = MLAT_DEF,
   localparam int RW   = rw_of(DW),
   localparam int IDW  = idw_of(NREQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req_valid,
   output logic [NREQ-1:0]    req_ready,
   input  logic [NREQ*DW-1:0] req_a,
   input  logic [NREQ*DW-1:0] req_b,
   input  logic [NREQ*DW-1:0] req_c,
   output logic [DW-1:0]      mult_a,
   output logic [DW-1:0]      mult_b,
   output logic [DW-1:0]      mult_c,
   input  logic [RW-1:0]      mult_result,
   output logic [NREQ-1:0]    rsp_valid,
   output logic [RW-1:0]      rsp_data,
   output logic               busy
`ifdef MULT_ARB_STATS_EN
   ,output logic [NREQ*16-1:0] grant_cnt
`endif
);

   logic [NREQ-1:0] grant;
   logic [IDW-1:0]  gid;
   logic            hs;

   logic [DW-1:0]   ma_q, ma_d, mb_q, mb_d, mc_q, mc_d;
   tag_t            tag_q [MLAT];
   tag_t            tag_d;
   tag_t            last;
   logic [NREQ-1:0] rv_q, rv_d;
   logic [RW-1:0]   rd_q, rd_d;

   rr_arbiter #(.NREQ(NREQ)) u_rr (
      .clk         (clk),
      .rst         (rst),
      .req_valid_i (req_valid),
      .adv_i       (hs),
      .grant_o     (grant),
      .id_o        (gid)
   );

   assign req_ready = grant;
   assign hs        = |grant;

   // Grant is one-hot, so OR-ing the masked operands selects the winner;
   // an idle cycle issues zeros.
   always_comb begin
      ma_d = '0;
      mb_d = '0;
      mc_d = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            ma_d = ma_d | req_a[i*DW +: DW];
            mb_d = mb_d | req_b[i*DW +: DW];
            mc_d = mc_d | req_c[i*DW +: DW];
         end
      end
      tag_d.valid = hs;
      tag_d.id    = IDW_MAX'(gid);
   end

   always_comb begin
      last = tag_q[MLAT-1];
      rv_d = '0;
      rd_d = '0;
      if (last.valid) begin
         rv_d = NREQ'(1) << last.id[IDW-1:0];
         rd_d = mult_result;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ma_q <= '0;
         mb_q <= '0;
         mc_q <= '0;
         rv_q <= '0;
         rd_q <= '0;
         for (int i = 0; i < MLAT; i++) tag_q[i] <= '0;
      end else begin
         ma_q     <= ma_d;
         mb_q     <= mb_d;
         mc_q     <= mc_d;
         rv_q     <= rv_d;
         rd_q     <= rd_d;
         tag_q[0] <= tag_d;
         for (int i = 1; i < MLAT; i++) tag_q[i] <= tag_q[i-1];
      end
   end

   always_comb begin
      busy = |rv_q;
      for (int i = 0; i < MLAT; i++) busy = busy | tag_q[i].valid;
   end

   assign mult_a    = ma_q;
   assign mult_b    = mb_q;
   assign mult_c    = mc_q;
   assign rsp_valid = rv_q;
   assign rsp_data  = rd_q;

`ifdef MULT_ARB_STATS_EN
   logic [15:0] cnt_q [NREQ];

   always_ff @(posedge clk) begin
      for (int i = 0; i < NREQ; i++) begin
         if (rst) begin
            cnt_q[i] <= '0;
         end else if (grant[i] && cnt_q[i] != 16'hFFFF) begin
            cnt_q[i] <= cnt_q[i] + 16'd1;
         end
      end
   end

   always_comb begin
      grant_cnt = '0;
      for (int i = 0; i < NREQ; i++) grant_cnt[i*16 +: 16] = cnt_q[i];
   end
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter driving a real pipeline_mult.
// Expected grants and results come from a round-robin model in the bench.
module tb_mult_arbiter;

   localparam int N    = 4;
   localparam int DW   = 8;
   localparam int MLAT = 3;
   localparam int RW   = 2 * DW + 1;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    req_valid, req_ready, rsp_valid;
   logic [N*DW-1:0] req_a, req_b, req_c;
   logic [DW-1:0]   mult_a, mult_b, mult_c;
   logic [RW-1:0]   mult_result, rsp_data;
   logic            busy;
`ifdef MULT_ARB_STATS_EN
   logic [N*16-1:0] grant_cnt;
`endif

   always #5 clk = ~clk;

   mult_arbiter #(.NREQ(N), .DW(DW), .MLAT(MLAT)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_a       (req_a),
      .req_b       (req_b),
      .req_c       (req_c),
      .mult_a      (mult_a),
      .mult_b      (mult_b),
      .mult_c      (mult_c),
      .mult_result (mult_result),
      .rsp_valid   (rsp_valid),
      .rsp_data    (rsp_data),
      .busy        (busy)
`ifdef MULT_ARB_STATS_EN
      ,.grant_cnt  (grant_cnt)
`endif
   );

   pipeline_mult #(.DW(DW), .MLAT(MLAT)) u_mul (
      .clk    (clk),
      .rst_n  (~rst),
      .a      (mult_a),
      .b      (mult_b),
      .c      (mult_c),
      .result (mult_result)
   );

   logic          v  [N];
   logic [DW-1:0] oa [N];
   logic [DW-1:0] ob [N];
   logic [DW-1:0] oc [N];

   always_comb begin
      for (int i = 0; i < N; i++) begin
         req_valid[i]       = v[i];
         req_a[i*DW +: DW]  = oa[i];
         req_b[i*DW +: DW]  = ob[i];
         req_c[i*DW +: DW]  = oc[i];
      end
   end

   typedef struct {
      int id;
      int res;
      int iss;
      int due;
   } exp_t;

   exp_t          q[$];
   int            cyc = 0;
   int            n_chk = 0;
   int            n_fail = 0;
   int            ptr_m = 0;
   logic [RW-1:0] last_rsp = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   function automatic int pick();
      for (int k = 0; k < N; k++) begin
         if (v[(ptr_m + k) % N]) return (ptr_m + k) % N;
      end
      return -1;
   endfunction

   // One clock: check the grant mid-cycle, book the expected result,
   // then check the issued operands just after the edge.
   task automatic step(output int g);
      logic r;
      @(negedge clk);
      #1;
      g = pick();
      r = rst;
      chk("req_ready", 64'(req_ready), (g >= 0) ? 64'(1 << g) : 64'd0);
      if (r) begin
         ptr_m = 0;
         q.delete();
      end else if (g >= 0) begin
         q.push_back('{g, int'(oa[g]) * int'(ob[g]) + int'(oc[g]),
                      cyc, cyc + MLAT + 1});
         ptr_m = (g + 1) % N;
      end
      @(posedge clk);
      #1;
      if (!r && g >= 0) begin
         chk("mult_a", 64'(mult_a), 64'(oa[g]));
         chk("mult_b", 64'(mult_b), 64'(ob[g]));
         chk("mult_c", 64'(mult_c), 64'(oc[g]));
         v[g] = 1'b0;
      end else begin
         chk("mult_a_idle", 64'(mult_a), 64'd0);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      logic eb;
      if (!rst) begin
         eb = 1'b0;
         foreach (q[k]) if (q[k].iss < cyc) eb = 1'b1;
         chk("busy", 64'(busy), 64'(eb));
         if (rsp_valid != '0) begin
            last_rsp = rsp_data;
            if (q.size() == 0) begin
               chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
            end else begin
               e = q.pop_front();
               chk("rsp_cycle", 64'(cyc), 64'(e.due));
               chk("rsp_valid", 64'(rsp_valid), 64'(1 << e.id));
               chk("rsp_data", 64'(rsp_data), 64'(e.res));
            end
         end else begin
            chk("rsp_data_idle", 64'(rsp_data), 64'd0);
            if (q.size() > 0 && q[0].due <= cyc) begin
               chk("rsp_missing", 64'(rsp_valid), 64'(1 << q[0].id));
               void'(q.pop_front());
            end
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      for (int i = 0; i < N; i++) v[i] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst   = 1'b0;
      ptr_m = 0;
      q.delete();
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_mult_a", 64'(mult_a), 64'd0);
      chk("rst_mult_b", 64'(mult_b), 64'd0);
      chk("rst_mult_c", 64'(mult_c), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_data", 64'(rsp_data), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
   endtask

   task automatic drain();
      int g;
      for (int i = 0; i < 20; i++) begin
         if (q.size() == 0) break;
         step(g);
      end
      chk("drain_left", 64'(q.size()), 64'd0);
   endtask

   task automatic set_op(input int i, input int a, input int b, input int c);
      v[i]  = 1'b1;
      oa[i] = DW'(a);
      ob[i] = DW'(b);
      oc[i] = DW'(c);
   endtask

   initial begin
      int g;
      int gseq[$];
      for (int i = 0; i < N; i++) begin
         v[i] = 1'b0; oa[i] = '0; ob[i] = '0; oc[i] = '0;
      end
      do_reset();

      set_op(2, 10, 20, 5);
      step(g);
      chk("single_grant", 64'(g), 64'd2);
      drain();
      chk("single_result", 64'(last_rsp), 64'd205);

      do_reset();
      for (int i = 0; i < N; i++) set_op(i, i + 1, 2, i);
      for (int k = 0; k < 8; k++) begin
         step(g);
         gseq.push_back(g);
         if (g >= 0) v[g] = 1'b1;
      end
      for (int i = 0; i < N; i++) v[i] = 1'b0;
      for (int k = 0; k < 8; k++) chk("rr_order", 64'(gseq[k]), 64'(k % N));
      drain();

      set_op(3, 7, 3, 1);
      step(g);
      set_op(1, 4, 4, 4);
      step(g);
      chk("wrap_grant", 64'(g), 64'd1);
      drain();

      set_op(0, 255, 255, 255);
      step(g);
      drain();
      chk("max_result", 64'(last_rsp), 64'd65280);
      chk("max_bit16", 64'(last_rsp[16]), 64'd0);

      set_op(0, 3, 3, 3);
      set_op(1, 5, 5, 5);
      step(g);
      step(g);
      set_op(2, 9, 9, 9);
      rst = 1'b1;
      step(g);
      rst  = 1'b0;
      v[2] = 1'b0;
      set_op(3, 2, 2, 2);
      step(g);
      chk("post_rst_grant", 64'(g), 64'd3);
      drain();

      for (int k = 0; k < 300; k++) begin
         for (int i = 0; i < N; i++) begin
            if (!v[i] && $urandom_range(0, 1) == 1) begin
               if ($urandom_range(0, 7) == 0) set_op(i, 255, 255, 255);
               else set_op(i, int'($urandom_range(0, 255)),
                           int'($urandom_range(0, 255)),
                           int'($urandom_range(0, 255)));
            end
         end
         step(g);
      end
      for (int i = 0; i < N; i++) v[i] = 1'b0;
      drain();

`ifdef MULT_ARB_STATS_EN
      do_reset();
      for (int k = 0; k < 70000; k++) begin
         set_op(0, 1, 1, 1);
         step(g);
      end
      v[0] = 1'b0;
      drain();
      chk("cnt0_sat", 64'(grant_cnt[15:0]), 64'd65535);
      for (int i = 1; i < N; i++)
         chk("cnt_other", 64'(grant_cnt[i*16 +: 16]), 64'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
